pulse_train_gen: RTL and testbench

Programmable pulse-train generator: on a start request it drives a single-bit output through N high/low periods of programmed cycle lengths, then signals completion. It is the stimulus side of the team's edge-detection path. It produces the rising and falling edges that downstream edge detectors consume, for timer ticks, strobes, and self-test waveforms.

---
 rtl/pulse_train_gen_pkg.sv | 14 +
 rtl/pulse_train_gen_if.sv | 25 ++
 rtl/pulse_train_gen_phase_counter.sv | 30 +++
 rtl/pulse_train_gen.sv | 130 +++++++++++++
 tb/tb_pulse_train_gen.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/pulse_train_gen_pkg.sv
// Shared definitions for the pulse-train generator: FSM state encoding and
// default field widths.
package pulse_train_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_e;

   localparam int DEF_CNT_W = 16;
   localparam int DEF_NUM_W = 8;

endpackage

// File: rtl/pulse_train_gen_if.sv
// Control/status bundle of the pulse-train generator; the requester drives the
// master side and the generator sits on the slave side.
interface pulse_train_gen_if #(
   parameter int CNT_W = pulse_train_pkg::DEF_CNT_W,
   parameter int NUM_W = pulse_train_pkg::DEF_NUM_W
);
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] high_cycles;
   logic [CNT_W-1:0] low_cycles;
   logic [NUM_W-1:0] num_pulses;
   logic             sig_out;
   logic             busy;
   logic             done;

   modport master (
      output start, abort, high_cycles, low_cycles, num_pulses,
      input  sig_out, busy, done
   );

   modport slave (
      input  start, abort, high_cycles, low_cycles, num_pulses,
      output sig_out, busy, done
   );
endinterface

// File: rtl/pulse_train_gen_phase_counter.sv
// Loadable down-counter with a zero flag; load takes priority over decrement
// and the count never goes below zero.
module phase_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count;

   // NOTE: sequential state is written only with non-blocking assignments so
   // every register samples pre-edge values, independent of process order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: N pulses of H high / L low cycles per
// start request, with abort and a one-cycle done on normal completion.
module pulse_train_gen
   import pulse_train_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int NUM_W = DEF_NUM_W
) (
   input logic               clk,
   input logic               rst,
   pulse_train_gen_if.slave  bus
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] h_m1_q, l_m1_q;
   logic             sig_out_q, busy_q, done_q;
   logic             done_d, cfg_latch;
   logic             ph_load, ph_dec, ph_zero;
   logic [CNT_W-1:0] ph_val;
   logic             pl_load, pl_dec, pl_zero;
   logic [NUM_W-1:0] pl_val;

   // A phase length of 0 behaves as 1; store length-1 so a reload is direct.
   function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] v);
      return (v == '0) ? '0 : v - 1'b1;
   endfunction

   phase_counter #(.W(CNT_W)) u_phase (
      .clk      (clk),
      .rst      (rst),
      .load     (ph_load),
      .load_val (ph_val),
      .dec      (ph_dec),
      .zero     (ph_zero)
   );

   phase_counter #(.W(NUM_W)) u_pulse (
      .clk      (clk),
      .rst      (rst),
      .load     (pl_load),
      .load_val (pl_val),
      .dec      (pl_dec),
      .zero     (pl_zero)
   );

   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d   = state_q;
      done_d    = 1'b0;
      cfg_latch = 1'b0;
      ph_load   = 1'b0;
      ph_dec    = 1'b0;
      ph_val    = '0;
      pl_load   = 1'b0;
      pl_dec    = 1'b0;
      pl_val    = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start && !bus.abort) begin
               if (bus.num_pulses != '0) begin
                  state_d   = ST_HIGH;
                  cfg_latch = 1'b1;
                  ph_load   = 1'b1;
                  ph_val    = len_m1(bus.high_cycles);
                  pl_load   = 1'b1;
                  pl_val    = bus.num_pulses - 1'b1;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_HIGH: begin
            if (bus.abort) begin
               state_d = ST_IDLE;
            end else if (ph_zero) begin
               state_d = ST_LOW;
               ph_load = 1'b1;
               ph_val  = l_m1_q;
            end else begin
               ph_dec = 1'b1;
            end
         end
         ST_LOW: begin
            if (bus.abort) begin
               state_d = ST_IDLE;
            end else if (ph_zero) begin
               if (pl_zero) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_HIGH;
                  pl_dec  = 1'b1;
                  ph_load = 1'b1;
                  ph_val  = h_m1_q;
               end
            end else begin
               ph_dec = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         h_m1_q    <= '0;
         l_m1_q    <= '0;
         sig_out_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sig_out_q <= (state_d == ST_HIGH);
         busy_q    <= (state_d != ST_IDLE);
         done_q    <= done_d;
         if (cfg_latch) begin
            h_m1_q <= len_m1(bus.high_cycles);
            l_m1_q <= len_m1(bus.low_cycles);
         end
      end
   end

   assign bus.sig_out = sig_out_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen: basic, zero-field, abort, re-trigger,
// async reset and limit cases against hand-computed waveforms.
module tb_pulse_train_gen;
   import pulse_train_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pulse_train_gen_if #(.CNT_W(16), .NUM_W(8)) bus ();
   pulse_train_gen_if #(.CNT_W(4),  .NUM_W(2)) lim ();

   pulse_train_gen #(.CNT_W(16), .NUM_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   pulse_train_gen #(.CNT_W(4), .NUM_W(2)) dut_lim (
      .clk (clk),
      .rst (rst),
      .bus (lim)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic s, input logic b, input logic d);
      check({tag, ".sig_out"}, {31'd0, bus.sig_out}, {31'd0, s});
      check({tag, ".busy"},    {31'd0, bus.busy},    {31'd0, b});
      check({tag, ".done"},    {31'd0, bus.done},    {31'd0, d});
   endtask

   task automatic launch(input int h, input int l, input int n);
      bus.high_cycles = 16'(h);
      bus.low_cycles  = 16'(l);
      bus.num_pulses  = 8'(n);
      bus.start       = 1'b1;
   endtask

   // Called in the cycle that raises start; checks cycles 1..len, then done.
   task automatic train(input string tag, input logic [63:0] exp_sig, input int len, input bit disturb);
      step();
      bus.start = 1'b0;
      for (int c = 1; c <= len; c++) begin
         check_outs($sformatf("%s.c%0d", tag, c), exp_sig[len-c], 1'b1, 1'b0);
         if (disturb && c == 2) begin
            bus.start       = 1'b1;
            bus.high_cycles = 16'd7;
            bus.low_cycles  = 16'd0;
            bus.num_pulses  = 8'd9;
         end
         if (disturb && c == 5) bus.start = 1'b0;
         step();
      end
      check_outs({tag, ".done_cycle"}, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      int   done_seen;
      int   busy_n;
      int   rises;
      logic prev;
      logic lim_done;

      bus.start = 1'b0; bus.abort = 1'b0;
      bus.high_cycles = '0; bus.low_cycles = '0; bus.num_pulses = '0;
      lim.start = 1'b0; lim.abort = 1'b0;
      lim.high_cycles = '0; lim.low_cycles = '0; lim.num_pulses = '0;

      // Reset state
      #12;
      check_outs("reset", 1'b0, 1'b0, 1'b0);
      check("reset.lim_busy", {31'd0, lim.busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step();
      check_outs("idle", 1'b0, 1'b0, 1'b0);

      // Basic train, then back-to-back train from the done cycle with
      // mid-train start pulses and config changes
      launch(3, 2, 2);
      train("basic", 64'b1110011100, 10, 1'b0);
      launch(3, 2, 2);
      train("retrig", 64'b1110011100, 10, 1'b1);
      step();
      check_outs("after_retrig", 1'b0, 1'b0, 1'b0);

      // Zero phase lengths act as 1
      launch(0, 0, 3);
      train("zero_len", 64'b101010, 6, 1'b0);
      step();

      // Empty train
      launch(5, 5, 0);
      step();
      bus.start = 1'b0;
      check_outs("empty", 1'b0, 1'b0, 1'b1);
      step();
      check_outs("empty.after", 1'b0, 1'b0, 1'b0);

      // Abort in LOW of first pulse
      launch(5, 5, 4);
      step();
      bus.start = 1'b0;
      for (int c = 1; c < 7; c++) step();
      check_outs("abort.c7", 1'b0, 1'b1, 1'b0);
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      check_outs("abort.c8", 1'b0, 1'b0, 1'b0);
      done_seen = 0;
      for (int c = 0; c < 50; c++) begin
         if (bus.done || bus.busy) done_seen++;
         step();
      end
      check("abort.quiet", 32'(done_seen), 32'd0);

      // start and abort together in IDLE: abort wins
      launch(3, 2, 2);
      bus.abort = 1'b1;
      step();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      check_outs("start_abort", 1'b0, 1'b0, 1'b0);
      step();
      check_outs("start_abort.next", 1'b0, 1'b0, 1'b0);

      // Asynchronous reset mid-HIGH
      launch(4, 2, 2);
      step();
      bus.start = 1'b0;
      step();
      check_outs("pre_rst", 1'b1, 1'b1, 1'b0);
      #2 rst = 1'b1;
      #1;
      check_outs("async_rst", 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      step();
      check_outs("post_rst_idle", 1'b0, 1'b0, 1'b0);
      launch(3, 2, 2);
      train("post_rst", 64'b1110011100, 10, 1'b0);

      // Limits on the narrow instance
      step();
      lim.high_cycles = 4'd15;
      lim.low_cycles  = 4'd15;
      lim.num_pulses  = 2'd3;
      lim.start       = 1'b1;
      step();
      lim.start = 1'b0;
      busy_n   = 0;
      rises    = 0;
      prev     = 1'b0;
      lim_done = 1'b0;
      for (int c = 0; c < 200 && !lim_done; c++) begin
         if (lim.busy) busy_n++;
         if (lim.sig_out && !prev) rises++;
         prev = lim.sig_out;
         if (lim.done) lim_done = 1'b1;
         else step();
      end
      check("limits.done_seen", {31'd0, lim_done}, 32'd1);
      check("limits.busy_cycles", 32'(busy_n), 32'd90);
      check("limits.rises", 32'(rises), 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
